// File: rtl/restoring_div_n_bit_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding.
package restoring_div_n_bit_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_RUN  = 2'd1;
  localparam logic [1:0] ENC_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ENC_IDLE,
    RUN  = ENC_RUN,
    DONE = ENC_DONE
  } state_e;

endpackage

// File: rtl/restoring_div_n_bit_if.sv
// Start/done handshake bundle between a requester and the restoring divider.
interface restoring_div_n_bit_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_div_n_bit_full_sub.sv
// W-bit ripple subtractor: a + ~b + 1 through a chain of full adders.
module full_sub_n_bit #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      logic b_inv;
      assign b_inv         = ~b[gi];
      assign diff[gi]      = a[gi] ^ b_inv ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b_inv) | (carry[gi] & (a[gi] ^ b_inv));
    end
  endgenerate

  // No carry out of the top bit means a < b.
  assign borrow = ~carry[W];

endmodule

// File: rtl/restoring_div_n_bit.sv
// Sequential N-bit unsigned restoring divider, one quotient bit per clock,
// behind a start/done handshake.
module restoring_div_n_bit
  import restoring_div_n_bit_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  restoring_div_n_bit_if.slave   bus
);

  localparam int CW = $clog2(N) + 1;

  state_e        state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic [N:0]    r_shift;
  logic [N:0]    t_diff;
  logic          t_borrow;
  logic          t_neg;

  // The restored remainder is always below the divisor, so N bits hold it;
  // only the shifted partial remainder needs the extra bit.
  assign r_shift = {r_q, q_q[N-1]};

  full_sub_n_bit #(.W(N + 1)) u_sub (
    .a      (r_shift),
    .b      ({1'b0, d_q}),
    .diff   (t_diff),
    .borrow (t_borrow)
  );

  assign t_neg = t_diff[N] | t_borrow;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    case (state_q)
      RUN: begin
        if (t_neg) begin
          r_d = r_shift[N-1:0];
          q_d = {q_q[N-2:0], 1'b0};
        end else begin
          r_d = t_diff[N-1:0];
          q_d = {q_q[N-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d      = 1'b1;
        quotient_d  = q_q;
        remainder_d = r_q;
        dbz_d       = (d_q == '0);
        state_d     = IDLE;
      end
      default: ;
    endcase

    // Acceptance from IDLE or straight out of DONE for back-to-back issue.
    if ((state_q == IDLE || state_q == DONE) && bus.start) begin
      d_d   = bus.divisor;
      cnt_d = '0;
      if (state_q == IDLE) begin
        dbz_d = 1'b0;
      end
      if (bus.divisor == '0) begin
        q_d     = '1;
        r_d     = bus.dividend;
        state_d = DONE;
      end else begin
        q_d     = bus.dividend;
        r_d     = '0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_div_n_bit.sv
// Directed bench for the 8-bit restoring divider: vector table, handshake
// corner cases and a strided operand sweep against / and %.
module tb_restoring_div_n_bit;

  localparam int N       = 8;
  localparam int TIMEOUT = 40;

  logic clk;
  logic rst;

  restoring_div_n_bit_if #(.N(N)) bus ();

  restoring_div_n_bit #(.N(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_dbz;
    int         exp_lat;
  } vec_t;

  int tests;
  int fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one accepted edge; returns at the negedge after acceptance.
  task automatic start_div(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[10];
  int   lat;
  int   saw_done;
  logic [7:0] sw_q;
  logic [7:0] sw_r;

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9};
    vecs[3] = '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 1};
    vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
    vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
    vecs[6] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9};
    vecs[7] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 9};
    vecs[8] = '{8'd17,  8'd16,  8'd1,   8'd1,   1'b0, 9};
    vecs[9] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1, 1};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset quotient", {24'd0, bus.quotient}, 32'd0);
    check("reset remainder", {24'd0, bus.remainder}, 32'd0);
    check("reset dbz", {31'd0, bus.div_by_zero}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      start_div(vecs[i].dvd, vecs[i].dvs);
      check($sformatf("vec%0d busy after start", i), {31'd0, bus.busy},
            {31'd0, (vecs[i].exp_lat != 1)});
      wait_done(lat);
      $display("[TB] vec%0d %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", i, vecs[i].dvd,
               vecs[i].dvs, bus.quotient, bus.remainder, bus.div_by_zero, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d quotient", i), {24'd0, bus.quotient}, {24'd0, vecs[i].exp_q});
      check($sformatf("vec%0d remainder", i), {24'd0, bus.remainder}, {24'd0, vecs[i].exp_r});
      check($sformatf("vec%0d dbz", i), {31'd0, bus.div_by_zero}, {31'd0, vecs[i].exp_dbz});
      @(negedge clk);
      check($sformatf("vec%0d done one cycle", i), {31'd0, bus.done}, 32'd0);
    end

    // div_by_zero from the last vector clears on the next accepted start;
    // results stay held while the new division runs.
    start_div(8'd9, 8'd3);
    check("dbz cleared on start", {31'd0, bus.div_by_zero}, 32'd0);
    check("quotient held during run", {24'd0, bus.quotient}, 32'd255);
    wait_done(lat);
    $display("[TB] 9/3 -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat);
    check("9/3 quotient", {24'd0, bus.quotient}, 32'd3);

    // start held high with new operands throughout a division.
    @(negedge clk);
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.dividend = 8'd50;
    bus.divisor  = 8'd3;
    wait_done(lat);
    bus.start = 1'b0;
    $display("[TB] 100/7 with start held -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat);
    check("held start latency", lat, 9);
    check("held start quotient", {24'd0, bus.quotient}, 32'd14);
    check("held start remainder", {24'd0, bus.remainder}, 32'd2);
    check("back-to-back busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    wait_done(lat);
    $display("[TB] 50/3 back-to-back -> q=%0d r=%0d lat=%0d", bus.quotient, bus.remainder, lat + 1);
    check("back-to-back latency", lat + 1, 9);
    check("back-to-back quotient", {24'd0, bus.quotient}, 32'd16);
    check("back-to-back remainder", {24'd0, bus.remainder}, 32'd2);

    // Reset in the middle of a division aborts without a done pulse.
    start_div(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset busy", {31'd0, bus.busy}, 32'd0);
    check("mid reset done", {31'd0, bus.done}, 32'd0);
    check("mid reset quotient", {24'd0, bus.quotient}, 32'd0);
    check("mid reset remainder", {24'd0, bus.remainder}, 32'd0);
    saw_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done++;
    end
    $display("[TB] mid-division reset -> done pulses afterwards=%0d", saw_done);
    check("no done after reset", saw_done, 0);

    // Strided operand sweep against the behavioural operators.
    for (int a = 0; a < 256; a += 17) begin
      for (int b = 0; b < 256; b += 23) begin
        if (b == 0) begin
          sw_q = 8'hFF;
          sw_r = 8'(a);
        end else begin
          sw_q = 8'(a / b);
          sw_r = 8'(a % b);
        end
        start_div(8'(a), 8'(b));
        wait_done(lat);
        $display("[TB] sweep %0d/%0d -> q=%0d r=%0d", a, b, bus.quotient, bus.remainder);
        check($sformatf("sweep %0d/%0d result", a, b), {16'd0, bus.quotient, bus.remainder},
              {16'd0, sw_q, sw_r});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
